// File: rtl/filter_frame_ctrl.sv
`default_nettype none
// ============================================================================
// filter_frame_ctrl : sequences one filter frame (arm, gate input, drain, done)
// Rev 1.0
// ============================================================================
module filter_frame_ctrl #(
    parameter  int PIXCNT    = 8,
    parameter  int ROWS      = 2049,
    parameter  int COLS      = 2448,
    parameter  int DRAIN_TMO = 4096,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS),
    localparam int BW        = $clog2(ROWS * (COLS / PIXCNT) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [RW-1:0] cfg_rows,
    input  logic [CW-1:0] cfg_cols,
    input  logic          cfg_bypass,
    input  logic          in_vld,
    input  logic          filt_out_vld,
    output logic          filt_new_frame,
    output logic [RW-1:0] filt_rows,
    output logic [CW-1:0] filt_cols,
    output logic          filt_bypass,
    output logic          filt_data_vld,
    output logic          busy,
    output logic          frame_done,
    output logic          err_cfg,
    output logic          err_overrun,
    output logic          err_timeout
);

    localparam int PW = $clog2(PIXCNT);
    localparam int TW = $clog2(DRAIN_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_rows;
    logic [CW-1:0] r_cols;
    logic          r_bypass;
    logic [BW-1:0] r_total;
    logic [BW-1:0] r_in_cnt;
    logic [BW-1:0] r_out_cnt;
    logic [TW-1:0] r_idle_cnt;
    logic          r_new_frame;
    logic          r_frame_done;
    logic          r_err_cfg;
    logic          r_err_ovr;
    logic          r_err_tmo;

    logic [31:0]   w_rows32;
    logic [31:0]   w_cols32;
    logic          w_cfg_ok;
    logic [BW-1:0] w_total;
    logic          w_run;
    logic          w_active;
    logic          w_in_full;
    logic          w_fwd;
    logic          w_out_en;
    logic [BW-1:0] w_out_next;
    logic          w_out_done;
    logic          w_overrun;

    assign w_rows32 = 32'(cfg_rows);
    assign w_cols32 = 32'(cfg_cols);

    // Columns must be a whole number of beats and at least two beats wide.
    assign w_cfg_ok = (w_rows32 >= 32'd3) && (w_rows32 <= 32'(ROWS)) &&
                      (w_cols32 >= 32'(2 * PIXCNT)) && (w_cols32 <= 32'(COLS)) &&
                      ((w_cols32 & 32'(PIXCNT - 1)) == 32'd0);
    assign w_total  = BW'(w_rows32 * (w_cols32 >> PW));

    assign w_run      = (r_state == S_RUN);
    assign w_active   = w_run || (r_state == S_DRAIN);
    assign w_in_full  = (r_in_cnt == r_total);
    assign w_fwd      = w_run && in_vld && !w_in_full;
    assign w_out_en   = w_active && filt_out_vld && (r_out_cnt != r_total);
    assign w_out_next = r_out_cnt + BW'(w_out_en);
    assign w_out_done = (w_out_next == r_total);
    assign w_overrun  = (in_vld && !w_fwd) || (start && (r_state != S_IDLE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rows       <= '0;
            r_cols       <= '0;
            r_bypass     <= 1'b0;
            r_total      <= '0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_new_frame  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_cfg    <= 1'b0;
            r_err_ovr    <= 1'b0;
            r_err_tmo    <= 1'b0;
        end else begin
            r_new_frame  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_cfg    <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_err_ovr    <= w_overrun;
            r_out_cnt    <= w_out_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_rows      <= cfg_rows;
                            r_cols      <= cfg_cols;
                            r_bypass    <= cfg_bypass;
                            r_total     <= w_total;
                            r_in_cnt    <= '0;
                            r_out_cnt   <= '0;
                            r_idle_cnt  <= '0;
                            r_new_frame <= 1'b1;
                            r_state     <= S_ARM;
                        end else begin
                            r_err_cfg <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_fwd) begin
                        r_in_cnt <= r_in_cnt + BW'(1);
                    end
                    if (w_in_full) begin
                        r_idle_cnt <= '0;
                        r_state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A beat that completes the frame wins over the idle timeout.
                    if (w_out_done) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (filt_out_vld) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == TW'(DRAIN_TMO - 1)) begin
                        r_err_tmo    <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign filt_new_frame = r_new_frame;
    assign filt_rows      = r_rows;
    assign filt_cols      = r_cols;
    assign filt_bypass    = r_bypass;
    assign filt_data_vld  = w_fwd;
    assign busy           = (r_state != S_IDLE);
    assign frame_done     = r_frame_done;
    assign err_cfg        = r_err_cfg;
    assign err_overrun    = r_err_ovr;
    assign err_timeout    = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_filter_frame_ctrl.sv
`default_nettype none
// tb_filter_frame_ctrl : expected pulse events are queued as stimulus is driven
// and matched in order against the pulses the controller produces.
module tb_filter_frame_ctrl;

    localparam int PIXCNT    = 8;
    localparam int ROWS      = 2049;
    localparam int COLS      = 2448;
    localparam int DRAIN_TMO = 16;
    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);

    localparam int EV_NEW  = 1;
    localparam int EV_CFG  = 2;
    localparam int EV_OVR  = 3;
    localparam int EV_TMO  = 4;
    localparam int EV_DONE = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [RW-1:0] cfg_rows;
    logic [CW-1:0] cfg_cols;
    logic          cfg_bypass;
    logic          in_vld;
    logic          filt_out_vld;
    logic          filt_new_frame;
    logic [RW-1:0] filt_rows;
    logic [CW-1:0] filt_cols;
    logic          filt_bypass;
    logic          filt_data_vld;
    logic          busy;
    logic          frame_done;
    logic          err_cfg;
    logic          err_overrun;
    logic          err_timeout;

    int n_total = 0;
    int n_bad   = 0;
    int n_fwd   = 0;
    int sb[$];

    always #5 clk = ~clk;

    filter_frame_ctrl #(
        .PIXCNT    (PIXCNT),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .DRAIN_TMO (DRAIN_TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_rows       (cfg_rows),
        .cfg_cols       (cfg_cols),
        .cfg_bypass     (cfg_bypass),
        .in_vld         (in_vld),
        .filt_out_vld   (filt_out_vld),
        .filt_new_frame (filt_new_frame),
        .filt_rows      (filt_rows),
        .filt_cols      (filt_cols),
        .filt_bypass    (filt_bypass),
        .filt_data_vld  (filt_data_vld),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_cfg        (err_cfg),
        .err_overrun    (err_overrun),
        .err_timeout    (err_timeout)
    );

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pop_evt(input int code);
        int e;
        if (sb.size() == 0) begin
            chk_eq("evt_unexpected", code, 0);
        end else begin
            e = sb.pop_front();
            chk_eq("evt_order", code, e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (filt_data_vld)  n_fwd++;
            if (filt_new_frame) pop_evt(EV_NEW);
            if (err_cfg)        pop_evt(EV_CFG);
            if (err_overrun)    pop_evt(EV_OVR);
            if (err_timeout)    pop_evt(EV_TMO);
            if (frame_done)     pop_evt(EV_DONE);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int rows, input int cols, input logic byp);
        start      = 1'b1;
        cfg_rows   = RW'(rows);
        cfg_cols   = CW'(cols);
        cfg_bypass = byp;
        tick();
        start = 1'b0;
    endtask

    // Leaves the bench at the first RUN cycle.
    task automatic start_frame(input int rows, input int cols, input logic byp);
        sb.push_back(EV_NEW);
        do_start(rows, cols, byp);
        tick();
    endtask

    task automatic run_beats(input int n_in, input int n_out);
        int n;
        n = (n_in > n_out) ? n_in : n_out;
        for (int i = 0; i < n; i++) begin
            in_vld       = (i < n_in);
            filt_out_vld = (i < n_out);
            tick();
        end
        in_vld       = 1'b0;
        filt_out_vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        chk_eq(tag, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb;
        int k;
        int in_sent;
        int out_sent;
        logic byp;
        int bad_rows [5] = '{4, 4, 2, 2050, 4};
        int bad_cols [5] = '{36, 8, 32, 32, 2456};

        reset        = 1'b1;
        start        = 1'b0;
        cfg_rows     = '0;
        cfg_cols     = '0;
        cfg_bypass   = 1'b0;
        in_vld       = 1'b0;
        filt_out_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_rows", int'(filt_rows), 0);
        chk_eq("rst_cols", int'(filt_cols), 0);
        chk_eq("rst_bypass", int'(filt_bypass), 0);
        chk_eq("rst_pulses", int'({filt_new_frame, frame_done, err_cfg, err_overrun, err_timeout}), 0);
        reset = 1'b0;
        tick();

        // Nominal 4x32 frame: 16 beats in, 16 beats out.
        fb = n_fwd;
        start_frame(4, 32, 1'b0);
        sb.push_back(EV_DONE);
        run_beats(16, 16);
        wait_idle("t1_idle");
        chk_eq("t1_fwd", n_fwd - fb, 16);
        chk_eq("t1_sb_left", sb.size(), 0);
        chk_eq("t1_rows", int'(filt_rows), 4);
        chk_eq("t1_cols", int'(filt_cols), 32);

        // Rejected configurations leave the latched config untouched.
        for (int i = 0; i < 5; i++) begin
            sb.push_back(EV_CFG);
            do_start(bad_rows[i], bad_cols[i], 1'b1);
            chk_eq("t2_busy", int'(busy), 0);
            tick();
        end
        chk_eq("t2_cols", int'(filt_cols), 32);
        chk_eq("t2_rows", int'(filt_rows), 4);
        chk_eq("t2_bypass", int'(filt_bypass), 0);
        chk_eq("t2_sb_left", sb.size(), 0);

        // Minimum frame 3x16 with one extra input beat.
        fb = n_fwd;
        start_frame(3, 16, 1'b0);
        sb.push_back(EV_OVR);
        run_beats(7, 0);
        chk_eq("t3_drain_busy", int'(busy), 1);
        chk_eq("t3_fwd", n_fwd - fb, 6);
        sb.push_back(EV_DONE);
        run_beats(0, 6);
        wait_idle("t3_idle");
        chk_eq("t3_sb_left", sb.size(), 0);

        // Drain timeout: no output beats at all.
        start_frame(3, 16, 1'b0);
        sb.push_back(EV_TMO);
        sb.push_back(EV_DONE);
        run_beats(6, 0);
        k = 0;
        while (!err_timeout && k < 100) begin
            tick();
            k++;
        end
        chk_eq("t4_tmo_latency", k, DRAIN_TMO + 1);
        chk_eq("t4_done_with_tmo", int'(frame_done), 1);
        wait_idle("t4_idle");
        chk_eq("t4_sb_left", sb.size(), 0);

        // Start with in_vld in IDLE, then restarts during ARM and RUN.
        fb = n_fwd;
        sb.push_back(EV_NEW);
        sb.push_back(EV_OVR);
        in_vld = 1'b1;
        do_start(4, 32, 1'b1);
        in_vld = 1'b0;
        sb.push_back(EV_OVR);
        start = 1'b1; cfg_rows = RW'(8); cfg_cols = CW'(64); cfg_bypass = 1'b0;
        tick();
        sb.push_back(EV_OVR);
        tick();
        start = 1'b0;
        chk_eq("t5_rows", int'(filt_rows), 4);
        chk_eq("t5_cols", int'(filt_cols), 32);
        chk_eq("t5_bypass", int'(filt_bypass), 1);
        sb.push_back(EV_DONE);
        run_beats(16, 16);
        wait_idle("t5_idle");
        chk_eq("t5_fwd", n_fwd - fb, 16);
        chk_eq("t5_sb_left", sb.size(), 0);

        // Reset in the middle of RUN.
        start_frame(4, 32, 1'b0);
        run_beats(5, 5);
        reset  = 1'b1;
        in_vld = 1'b1;
        #1;
        chk_eq("t6_busy", int'(busy), 0);
        chk_eq("t6_rows", int'(filt_rows), 0);
        chk_eq("t6_cols", int'(filt_cols), 0);
        chk_eq("t6_gate", int'(filt_data_vld), 0);
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) tick();
        chk_eq("t6_no_events", sb.size(), 0);
        fb = n_fwd;
        start_frame(4, 32, 1'b0);
        sb.push_back(EV_OVR);
        sb.push_back(EV_DONE);
        run_beats(17, 16);
        wait_idle("t6_idle");
        chk_eq("t6_fwd", n_fwd - fb, 16);
        chk_eq("t6_sb_left", sb.size(), 0);

        // 5x48 frame with random gaps on both sides.
        fb = n_fwd;
        byp = 1'($urandom_range(0, 1));
        start_frame(5, 48, byp);
        sb.push_back(EV_DONE);
        in_sent  = 0;
        out_sent = 0;
        for (int c = 0; c < 1000 && (in_sent < 30 || out_sent < 30); c++) begin
            in_vld       = (in_sent < 30) && ($urandom_range(0, 3) != 0);
            filt_out_vld = (out_sent < 30) && ($urandom_range(0, 3) != 0);
            tick();
            if (in_vld)       in_sent++;
            if (filt_out_vld) out_sent++;
        end
        in_vld       = 1'b0;
        filt_out_vld = 1'b0;
        wait_idle("t7_idle");
        chk_eq("t7_fwd", n_fwd - fb, 30);
        chk_eq("t7_bypass", int'(filt_bypass), int'(byp));
        chk_eq("t7_sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_frame_ctrl.md
FILTER_FRAME_CTRL -- requirements
Module: filter_frame_ctrl

Interface
REQ-001 SHALL have parameter PIXCNT, default 8, pixels per beat (power of 2).
REQ-002 SHALL have parameter ROWS, default 2049, max frame rows.
REQ-003 SHALL have parameter COLS, default 2448, max frame columns.
REQ-004 SHALL have parameter DRAIN_TMO, default 4096, max drain cycles without an output beat.
REQ-005 SHALL have localparams RW=$clog2(ROWS), CW=$clog2(COLS), BW=$clog2(ROWS*(COLS/PIXCNT)+1).
REQ-006 clk  input  1  clock; all logic on posedge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 start  input  1  frame start request pulse.
REQ-009 cfg_rows  input  RW  requested frame rows.
REQ-010 cfg_cols  input  CW  requested frame columns.
REQ-011 cfg_bypass  input  1  requested filter bypass.
REQ-012 in_vld  input  1  source beat valid.
REQ-013 filt_out_vld  input  1  filter output beat valid.
REQ-014 filt_new_frame  output  1  one-cycle filter frame clear.
REQ-015 filt_rows / filt_cols / filt_bypass  output  RW / CW / 1  latched config to filter.
REQ-016 filt_data_vld  output  1  gated beat valid to filter.
REQ-017 busy  output  1  high in any state but IDLE.
REQ-018 frame_done  output  1  one-cycle completion pulse.
REQ-019 err_cfg / err_overrun / err_timeout  output  1 each  one-cycle error pulses.

Function
REQ-020 SHALL implement states IDLE, ARM, RUN, DRAIN, DONE.
REQ-021 IDLE + start SHALL validate config: cfg_rows>=3, cfg_rows<=ROWS, cfg_cols>=2*PIXCNT, cfg_cols<=COLS, cfg_cols%PIXCNT==0.
REQ-022 Invalid config SHALL pulse err_cfg next cycle and remain in IDLE; outputs otherwise unchanged.
REQ-023 Valid config SHALL latch filt_rows/filt_cols/filt_bypass, compute total=cfg_rows*(cfg_cols/PIXCNT) in BW bits, go to ARM.
REQ-024 Latched config SHALL change only on an accepted start; cfg_* ignored in all other states/cycles.
REQ-025 ARM SHALL last exactly one cycle with filt_new_frame=1, then go to RUN.
REQ-026 RUN: filt_data_vld SHALL equal in_vld combinationally (zero latency); in_cnt increments per passed beat.
REQ-027 When in_cnt reaches total, SHALL go to DRAIN next cycle; filt_data_vld forced 0 from that cycle on.
REQ-028 in_vld while not in RUN, or in RUN after in_cnt==total, SHALL be dropped and pulse err_overrun next cycle.
REQ-029 out_cnt SHALL count filt_out_vld beats in RUN and DRAIN; beats in other states ignored.
REQ-030 DRAIN SHALL go to DONE when out_cnt==total (including reaching total in the same cycle as entry).
REQ-031 DRAIN idle counter SHALL reset on every filt_out_vld and on DRAIN entry; reaching DRAIN_TMO SHALL pulse err_timeout and go to DONE.
REQ-032 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-033 start outside IDLE SHALL be ignored and pulse err_overrun.
REQ-034 Simultaneous start and in_vld in IDLE: in_vld dropped (err_overrun), start accepted.
REQ-035 Counters SHALL not wrap; saturate at total; cleared on ARM entry.
REQ-036 frame_done and err_* SHALL be registered outputs.

Reset
REQ-037 On reset: state=IDLE, all counters 0, filt_rows/filt_cols 0, filt_bypass 0, all pulse outputs 0, busy 0.
REQ-038 Reset mid-frame SHALL abort immediately with no frame_done and no error pulse.

Verification
REQ-039 rows=4, cols=32, PIXCNT=8, start, 16 in_vld beats, 16 filt_out_vld -> one filt_new_frame, 16 filt_data_vld, frame_done once, no errors.
REQ-040 start with cols=36 -> err_cfg pulse, busy stays 0, filt_cols unchanged.
REQ-041 rows=3, cols=16, 7 in_vld beats -> 6 forwarded, err_overrun once, state DRAIN.
REQ-042 DRAIN_TMO=16, no filt_out_vld after input -> err_timeout at cycle 16 of DRAIN, then frame_done.
REQ-043 Second start during RUN with new cfg -> err_overrun, filt_rows/filt_cols unchanged.
REQ-044 reset asserted mid-RUN -> busy=0 same cycle, counters 0, no frame_done.
